// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths and FSM state type for the SRAM arbiter
package sram_arb_pkg;
    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    localparam int BE_W = 4;
    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_LO_REL, WR_HI, WR_HI_REL, DONE
    } sram_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requesters, pointer advances on accept
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant,
    output logic         valid
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] last_grant, pick, j;
    // search starts one past the previous winner and wraps
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pick = last_grant;
        j = '0;
        for (int i = 1; i <= N; i++) begin
            j = W'((int'(last_grant) + i) % N);
            if (!valid && req[j]) begin
                valid = 1'b1;
                pick = j;
            end
        end
        grant[pick] = valid;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset)
            last_grant <= W'(N - 1);
        else if (accept && valid)
            last_grant <= pick;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin word clients onto a 16-bit async SRAM, two halfword accesses per word
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_READ  = 2,
    parameter int N_WRITE = 1,
    parameter int ADDR_W  = 19
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_READ-1:0]                   rd_req,
    input  logic [N_READ-1:0][ADDR_W-1:0]       rd_addr,
    output logic [N_READ-1:0]                   rd_ready,
    output logic [DATA_W-1:0]                   rd_data,
    input  logic [N_WRITE-1:0]                  wr_req,
    input  logic [N_WRITE-1:0][ADDR_W-1:0]      wr_addr,
    input  logic [N_WRITE-1:0][DATA_W-1:0]      wr_data,
    input  logic [N_WRITE-1:0][BE_W-1:0]        wr_be,
    output logic [N_WRITE-1:0]                  wr_ready,
    output logic [ADDR_W:0]                     sram_addr,
    input  logic [HALF_W-1:0]                   sram_dq_in,
    output logic [HALF_W-1:0]                   sram_dq_out,
    output logic                                sram_dq_oe,
    output logic                                sram_oe_n,
    output logic                                sram_we_n,
    output logic                                sram_ub_n,
    output logic                                sram_lb_n,
    output logic                                busy
);
    localparam int T = N_READ + N_WRITE;
    localparam int IW = T > 1 ? $clog2(T) : 1;
    sram_arb_state_t state, next;
    logic [T-1:0] grant, n_ready;
    logic valid, g_wr, hi, rd, wr;
    logic [ADDR_W-1:0] g_addr, a_q, ca;
    logic [DATA_W-1:0] g_data, d_q, cd;
    logic [BE_W-1:0] g_be, be_q, cbe;
    logic [IW-1:0] g_idx, idx_q, cidx;
    logic [ADDR_W:0] n_addr;
    logic [HALF_W-1:0] n_dq;
    logic n_dq_oe, n_oe_n, n_we_n, n_ub_n, n_lb_n;

    rr_arbiter #(.N(T)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({wr_req, rd_req}),
        .accept (state == IDLE),
        .grant  (grant),
        .valid  (valid)
    );

    always_comb begin
        g_addr = '0;
        g_data = '0;
        g_be = '0;
        g_idx = '0;
        g_wr = 1'b0;
        for (int i = 0; i < N_READ; i++)
            if (grant[i]) begin
                g_addr = rd_addr[i];
                g_idx = IW'(i);
            end
        for (int i = 0; i < N_WRITE; i++)
            if (grant[N_READ+i]) begin
                g_addr = wr_addr[i];
                g_data = wr_data[i];
                g_be = wr_be[i];
                g_idx = IW'(N_READ + i);
                g_wr = 1'b1;
            end
    end

    // in IDLE the access is still being granted, so use the live mux rather than the latch
    assign ca = state == IDLE ? g_addr : a_q;
    assign cd = state == IDLE ? g_data : d_q;
    assign cbe = state == IDLE ? g_be : be_q;
    assign cidx = state == IDLE ? g_idx : idx_q;
    assign busy = state != IDLE;

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = !valid ? IDLE : !g_wr ? RD_LO : |g_be[1:0] ? WR_LO : |g_be[3:2] ? WR_HI : DONE;
            RD_LO:     next = RD_HI;
            RD_HI:     next = DONE;
            WR_LO:     next = WR_LO_REL;
            WR_LO_REL: next = |be_q[3:2] ? WR_HI : DONE;
            WR_HI:     next = WR_HI_REL;
            WR_HI_REL: next = DONE;
            default:   next = IDLE;
        endcase
    end

    // pins are registered from the state being entered
    always_comb begin
        hi = next == RD_HI || next == WR_HI || next == WR_HI_REL;
        rd = next == RD_LO || next == RD_HI;
        wr = next == WR_LO || next == WR_LO_REL || next == WR_HI || next == WR_HI_REL;
        n_addr = (rd || wr) ? {ca, hi} : sram_addr;
        n_dq = wr ? (hi ? cd[DATA_W-1:HALF_W] : cd[HALF_W-1:0]) : sram_dq_out;
        n_dq_oe = wr;
        n_oe_n = !rd;
        n_we_n = !(next == WR_LO || next == WR_HI);
        n_lb_n = rd ? 1'b0 : wr ? !(hi ? cbe[2] : cbe[0]) : 1'b1;
        n_ub_n = rd ? 1'b0 : wr ? !(hi ? cbe[3] : cbe[1]) : 1'b1;
        n_ready = next == DONE ? T'(1) << cidx : '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            a_q <= '0;
            d_q <= '0;
            be_q <= '0;
            idx_q <= '0;
            sram_addr <= '0;
            sram_dq_out <= '0;
            sram_dq_oe <= 1'b0;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            rd_ready <= '0;
            wr_ready <= '0;
            rd_data <= '0;
        end else begin
            state <= next;
            if (state == IDLE) begin
                a_q <= g_addr;
                d_q <= g_data;
                be_q <= g_be;
                idx_q <= g_idx;
            end
            sram_addr <= n_addr;
            sram_dq_out <= n_dq;
            sram_dq_oe <= n_dq_oe;
            sram_oe_n <= n_oe_n;
            sram_we_n <= n_we_n;
            sram_ub_n <= n_ub_n;
            sram_lb_n <= n_lb_n;
            rd_ready <= n_ready[N_READ-1:0];
            wr_ready <= n_ready[T-1:N_READ];
            if (state == RD_LO)
                rd_data[HALF_W-1:0] <= sram_dq_in;
            if (state == RD_HI)
                rd_data[DATA_W-1:HALF_W] <= sram_dq_in;
        end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector bench for sram_arbiter with a behavioural async SRAM
module tb_sram_arbiter;
    localparam int NR = 2;
    localparam int NW = 1;
    localparam int AW = 19;

    typedef struct {
        bit          wr;
        int          cl;
        logic [AW-1:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load = 1'b1;
    logic [NR-1:0] rd_req = '0;
    logic [NR-1:0][AW-1:0] rd_addr = '0;
    logic [NR-1:0] rd_ready;
    logic [31:0] rd_data;
    logic [NW-1:0] wr_req = '0;
    logic [NW-1:0][AW-1:0] wr_addr = '0;
    logic [NW-1:0][31:0] wr_data = '0;
    logic [NW-1:0][3:0] wr_be = '0;
    logic [NW-1:0] wr_ready;
    logic [AW:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy;

    logic [15:0] mem [64];
    int wcnt [64];
    int strobe_cnt = 0;
    int clash_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    sram_arbiter #(.N_READ(NR), .N_WRITE(NW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .wr_ready    (wr_ready),
        .sram_addr   (sram_addr),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n),
        .busy        (busy)
    );

    assign sram_dq_in = sram_oe_n ? 16'h0 : mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= (i == 32) ? 16'hBEEF : (i == 33) ? 16'hDEAD : 16'hA000 + 16'(i);
                wcnt[i] <= 0;
            end
        end else if (!sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[5:0]][7:0] <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[5:0]][15:8] <= sram_dq_out[15:8];
            wcnt[sram_addr[5:0]] <= wcnt[sram_addr[5:0]] + 1;
        end
    end

    always @(negedge clk) begin
        if (!sram_oe_n || !sram_we_n || !sram_ub_n || !sram_lb_n) strobe_cnt++;
        if ((!sram_oe_n && sram_dq_oe) || (!sram_we_n && !sram_dq_oe)) clash_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " rd_ready"}, rd_ready, 0);
        chk({tag, " wr_ready"}, wr_ready, 0);
        chk({tag, " rd_data"}, rd_data, 0);
        chk({tag, " sram_addr"}, sram_addr, 0);
        chk({tag, " dq_out"}, sram_dq_out, 0);
        chk({tag, " dq_oe"}, sram_dq_oe, 0);
        chk({tag, " strobes"}, {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [AW:0] seen [11];
        int lat = 0;
        int s0 = strobe_cnt;
        int lo = int'(v.addr[4:0]) * 2;
        @(negedge clk);
        if (v.wr) begin
            wr_addr[0] = v.addr;
            wr_data[0] = v.data;
            wr_be[0] = v.be;
            wr_req[0] = 1'b1;
        end else begin
            rd_addr[v.cl] = v.addr;
            rd_req[v.cl] = 1'b1;
        end
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            seen[n] = sram_addr;
            if (v.wr ? wr_ready[0] : rd_ready[v.cl]) lat = n;
        end
        rd_req = '0;
        wr_req = '0;
        chk($sformatf("v%0d latency", id), lat, v.lat);
        if (v.wr) begin
            chk($sformatf("v%0d mem word", id), {mem[lo+1], mem[lo]}, v.exp);
            if (v.be == 4'h0) chk($sformatf("v%0d strobes", id), strobe_cnt - s0, 0);
        end else begin
            chk($sformatf("v%0d rd_data", id), rd_data, v.exp);
            chk($sformatf("v%0d addr lo", id), seen[1], {v.addr, 1'b0});
            chk($sformatf("v%0d addr hi", id), seen[2], {v.addr, 1'b1});
        end
    endtask

    initial begin
        int order [6];
        int k;
        int c8, c9;
        vecs[0] = '{0, 0, 19'h10, 32'h0,        4'h0, 3, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 19'h03, 32'h0,        4'h0, 3, 32'hA007A006};
        vecs[2] = '{1, 0, 19'h04, 32'h12345678, 4'hC, 3, 32'h1234A008};
        vecs[3] = '{1, 0, 19'h05, 32'hCAFEF00D, 4'hF, 5, 32'hCAFEF00D};
        vecs[4] = '{1, 0, 19'h06, 32'h11223344, 4'h1, 3, 32'hA00DA044};
        vecs[5] = '{1, 0, 19'h07, 32'hFFFFFFFF, 4'h0, 1, 32'hA00FA00E};
        vecs[6] = '{0, 0, 19'h04, 32'h0,        4'h0, 3, 32'h1234A008};
        vecs[7] = '{0, 1, 19'h06, 32'h0,        4'h0, 3, 32'hA00DA044};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        reset = 1'b0;
        load = 1'b0;

        for (int i = 0; i < 8; i++) begin
            c8 = wcnt[8];
            c9 = wcnt[9];
            run_vec(vecs[i], i);
            if (i == 2) begin
                chk("partial no access 8", wcnt[8] - c8, 0);
                chk("partial one write 9", wcnt[9] - c9, 1);
            end
        end

        // reset in the middle of a read
        @(negedge clk);
        rd_addr[0] = 19'h10;
        rd_req[0] = 1'b1;
        @(negedge clk);
        chk("read started", sram_oe_n, 0);
        #2 reset = 1'b1;
        rd_req = '0;
        #1 check_reset("midsim");
        @(negedge clk);
        reset = 1'b0;

        // round robin with everyone requesting continuously
        wr_addr[0] = 19'h08;
        wr_data[0] = 32'h55AA55AA;
        wr_be[0] = 4'hF;
        rd_addr[0] = 19'h10;
        rd_addr[1] = 19'h03;
        @(negedge clk);
        rd_req = 2'b11;
        wr_req = 1'b1;
        k = 0;
        for (int n = 0; n < 60 && k < 6; n++) begin
            @(negedge clk);
            if (rd_ready[0]) begin order[k] = 0; k++; end
            else if (rd_ready[1]) begin order[k] = 1; k++; end
            else if (wr_ready[0]) begin order[k] = 2; k++; end
        end
        rd_req = '0;
        wr_req = '0;
        chk("rr grant count", k, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr order %0d", i), order[i], i % 3);

        // reset while the low half is being written
        repeat (2) @(negedge clk);
        wr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wr_lo we_n low", sram_we_n, 0);
        #2 reset = 1'b1;
        #1 chk("rst wr we_n", sram_we_n, 1);
        chk("rst wr dq_oe", sram_dq_oe, 0);
        chk("rst wr busy", busy, 0);
        rd_req = 2'b11;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("rst no ready", {rd_ready, wr_ready}, 0);
        end
        reset = 1'b0;
        k = 0;
        for (int n = 0; n < 20 && k == 0; n++) begin
            @(negedge clk);
            if (rd_ready != 0 || wr_ready != 0) begin
                k = 1;
                chk("post rst first grant", {rd_ready, wr_ready}, 3'b010);
            end
        end
        chk("post rst granted", k, 1);
        rd_req = '0;
        wr_req = '0;
        repeat (6) @(negedge clk);
        chk("oe/dq_oe/we_n clash", clash_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
